// File: rtl/rtap_sscan_req_ctrl.sv
// TAP-side shadow-scan request sequencer: issues one core debug request, captures the
// response at a fixed latency and returns it to the TAP as a parallel word or a serial stream.
module rtap_sscan_req_ctrl #(
  parameter int BUS_W     = 94,
  parameter int CORE_ID_W = 4,
  parameter int RESP_LAT  = 1,
  parameter int SNAP_W    = 94
) (
  input  logic                 rclk,
  input  logic                 rst,
  input  logic                 tap_req_val,
  output logic                 tap_req_rdy,
  input  logic [CORE_ID_W-1:0] tap_req_core_id,
  input  logic [1:0]           tap_req_threadid,
  input  logic [BUS_W-1:0]     tap_req_data,
  output logic                 rtap_core_val,
  output logic [CORE_ID_W-1:0] rtap_core_id,
  output logic [1:0]           rtap_core_threadid,
  output logic [BUS_W-1:0]     rtap_core_data,
  input  logic [BUS_W-1:0]     core_rtap_data,
  output logic                 tap_resp_val,
  input  logic                 tap_resp_rdy,
  output logic [BUS_W-1:0]     tap_resp_data,
  input  logic                 tap_shift_en,
  output logic                 tap_shift_out,
  output logic [7:0]           tap_xact_cnt
);

  localparam int BCNT_W = $clog2(SNAP_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_SHIFT
  } state_t;

  state_t                 state_q, state_d;
  logic [CORE_ID_W-1:0]   id_q;
  logic [1:0]             tid_q;
  logic [BUS_W-1:0]       data_q;
  logic [BUS_W-1:0]       cap_q;
  logic [BUS_W-1:0]       sreg_q;
  logic [3:0]             lat_q;
  logic [BCNT_W-1:0]      bcnt_q;
  logic [7:0]             xact_q;
  logic                   last_bit;
  logic                   xact_done;

  assign last_bit  = (bcnt_q == BCNT_W'(SNAP_W - 1));
  assign xact_done = ((state_q == S_HOLD) && tap_resp_rdy) ||
                     ((state_q == S_SHIFT) && tap_shift_en && last_bit);

  always_comb begin
    // NOTE: state_d takes its hold value first so every path assigns it; no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tap_req_val) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (lat_q == 4'd0) state_d = S_HOLD;
      S_HOLD: begin
        // rdy wins over shift_en when both are asserted
        if (tap_resp_rdy)      state_d = S_IDLE;
        else if (tap_shift_en) state_d = S_SHIFT;
      end
      S_SHIFT: if (tap_shift_en && last_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      tid_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      sreg_q  <= '0;
      lat_q   <= '0;
      bcnt_q  <= '0;
      xact_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && tap_req_val) begin
        id_q   <= tap_req_core_id;
        tid_q  <= tap_req_threadid;
        data_q <= tap_req_data;
      end
      if (state_q == S_ISSUE) lat_q <= 4'(RESP_LAT - 1);
      if (state_q == S_WAIT) begin
        if (lat_q == 4'd0) begin
          cap_q  <= core_rtap_data;
          sreg_q <= core_rtap_data;
          bcnt_q <= '0;
        end else begin
          lat_q <= lat_q - 4'd1;
        end
      end
      if (state_q == S_SHIFT && tap_shift_en) begin
        sreg_q <= {1'b0, sreg_q[BUS_W-1:1]};
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (xact_done) xact_q <= xact_q + 8'd1;
    end
  end

  assign tap_req_rdy        = (state_q == S_IDLE);
  assign rtap_core_val      = (state_q == S_ISSUE);
  assign rtap_core_id       = (state_q == S_ISSUE) ? id_q   : '0;
  assign rtap_core_threadid = (state_q == S_ISSUE) ? tid_q  : '0;
  assign rtap_core_data     = (state_q == S_ISSUE) ? data_q : '0;
  assign tap_resp_val       = (state_q == S_HOLD);
  assign tap_resp_data      = cap_q;
  assign tap_shift_out      = (state_q == S_SHIFT) ? sreg_q[0] : 1'b0;
  assign tap_xact_cnt       = xact_q;

endmodule

// File: tb/tb_rtap_sscan_req_ctrl.sv
// Directed bench: one instance at RESP_LAT=1 and one at RESP_LAT=3, each fed by a small core model.
module tb_rtap_sscan_req_ctrl;

  localparam int BUS_W = 94;
  localparam int CW    = 4;

  logic             rclk;
  logic             rst;
  logic [CW-1:0]    req_id;
  logic [1:0]       req_tid;
  logic [BUS_W-1:0] req_data;
  logic             resp_rdy;
  logic             shift_en;

  logic             val1, val3;
  logic             req_rdy1, req_rdy3;
  logic             core_val1, core_val3;
  logic [CW-1:0]    core_id1, core_id3;
  logic [1:0]       core_tid1, core_tid3;
  logic [BUS_W-1:0] core_data1, core_data3;
  logic [BUS_W-1:0] core_resp1, core_resp3;
  logic             resp_val1, resp_val3;
  logic [BUS_W-1:0] resp_data1, resp_data3;
  logic             shift_out1, shift_out3;
  logic [7:0]       xact1, xact3;

  logic [BUS_W-1:0] resp_word1;
  logic             v1_d;
  logic             v3_d1, v3_d2, v3_d3, v3_d4;

  int n_checks = 0;
  int n_fail   = 0;

  rtap_sscan_req_ctrl #(.RESP_LAT(1)) dut1 (
    .rclk(rclk), .rst(rst),
    .tap_req_val(val1), .tap_req_rdy(req_rdy1),
    .tap_req_core_id(req_id), .tap_req_threadid(req_tid), .tap_req_data(req_data),
    .rtap_core_val(core_val1), .rtap_core_id(core_id1),
    .rtap_core_threadid(core_tid1), .rtap_core_data(core_data1),
    .core_rtap_data(core_resp1),
    .tap_resp_val(resp_val1), .tap_resp_rdy(resp_rdy), .tap_resp_data(resp_data1),
    .tap_shift_en(shift_en), .tap_shift_out(shift_out1), .tap_xact_cnt(xact1)
  );

  rtap_sscan_req_ctrl #(.RESP_LAT(3)) dut3 (
    .rclk(rclk), .rst(rst),
    .tap_req_val(val3), .tap_req_rdy(req_rdy3),
    .tap_req_core_id(req_id), .tap_req_threadid(req_tid), .tap_req_data(req_data),
    .rtap_core_val(core_val3), .rtap_core_id(core_id3),
    .rtap_core_threadid(core_tid3), .rtap_core_data(core_data3),
    .core_rtap_data(core_resp3),
    .tap_resp_val(resp_val3), .tap_resp_rdy(resp_rdy), .tap_resp_data(resp_data3),
    .tap_shift_en(shift_en), .tap_shift_out(shift_out3), .tap_xact_cnt(xact3)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Core models: dut1 answers one cycle after its strobe; dut3 answers 0x55 at issue+3
  // surrounded by 0xFF decoys at issue+2 and issue+4.
  always @(posedge rclk) begin
    v1_d  <= core_val1;
    v3_d1 <= core_val3;
    v3_d2 <= v3_d1;
    v3_d3 <= v3_d2;
    v3_d4 <= v3_d3;
  end
  assign core_resp1 = v1_d ? resp_word1 : '0;
  assign core_resp3 = v3_d3 ? BUS_W'(8'h55) : ((v3_d2 || v3_d4) ? BUS_W'(8'hFF) : '0);

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // One parallel transaction on dut1 with resp_rdy high: accept, ISSUE, WAIT, HOLD, back to IDLE.
  task automatic xact_dut1();
    val1 = 1'b1;
    tick();
    val1 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int strobes;
    int resp_seen;
    logic [BUS_W-1:0] serial_exp;

    rst = 1'b1; val1 = 1'b0; val3 = 1'b0;
    req_id = '0; req_tid = '0; req_data = '0;
    resp_rdy = 1'b0; shift_en = 1'b0;
    resp_word1 = '0;
    v1_d = 1'b0; v3_d1 = 1'b0; v3_d2 = 1'b0; v3_d3 = 1'b0; v3_d4 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_rdy1", req_rdy1, 1);
    check("rst_req_rdy3", req_rdy3, 1);
    check("rst_core_val1", core_val1, 0);
    check("rst_resp_val1", resp_val1, 0);
    check("rst_resp_data1", resp_data1, 0);
    check("rst_shift_out3", shift_out3, 0);
    check("rst_xact1", xact1, 0);

    // Basic parallel transaction
    resp_word1 = BUS_W'(40'h2A_DEAD_BEEF);
    resp_rdy = 1'b1;
    req_id = 4'd3; req_tid = 2'd2; req_data = '0;
    val1 = 1'b1;
    tick();
    val1 = 1'b0;
    check("basic_core_val", core_val1, 1);
    check("basic_core_id", core_id1, 3);
    check("basic_core_tid", core_tid1, 2);
    check("basic_core_data", core_data1, 0);
    check("basic_rdy_busy", req_rdy1, 0);
    tick();
    check("basic_core_val_once", core_val1, 0);
    check("basic_core_id_zero", core_id1, 0);
    check("basic_resp_val_wait", resp_val1, 0);
    tick();
    check("basic_resp_val", resp_val1, 1);
    check("basic_resp_data", resp_data1, 40'h2A_DEAD_BEEF);
    tick();
    check("basic_resp_val_once", resp_val1, 0);
    check("basic_rdy_again", req_rdy1, 1);
    check("basic_xact", xact1, 1);
    check("basic_data_kept", resp_data1, 40'h2A_DEAD_BEEF);

    // Latency 3: only the issue+3 value is captured
    val3 = 1'b1;
    tick();
    val3 = 1'b0;
    check("lat_core_val", core_val3, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_no_resp_yet", resp_val3, 0);
    end
    tick();
    check("lat_resp_val", resp_val3, 1);
    check("lat_resp_data", resp_data3, 8'h55);
    tick();
    check("lat_xact", xact3, 1);

    // Serial: 94'h5 shifted out LSB first
    resp_word1 = BUS_W'(3'b101);
    serial_exp = BUS_W'(3'b101);
    resp_rdy = 1'b0;
    val1 = 1'b1;
    tick();
    val1 = 1'b0;
    repeat (2) tick();
    check("ser_hold_val", resp_val1, 1);
    check("ser_hold_out", shift_out1, 0);
    shift_en = 1'b1;
    tick();
    check("ser_shift_resp_val", resp_val1, 0);
    for (int i = 0; i < 94; i++) begin
      check("ser_bit", shift_out1, serial_exp[i]);
      check("ser_busy", req_rdy1, 0);
      tick();
    end
    check("ser_idle", req_rdy1, 1);
    check("ser_out_idle", shift_out1, 0);
    check("ser_xact", xact1, 2);

    // Stall with rdy high in SHIFT: pattern 1,0,0,1 consumes two bits of 0b010
    shift_en = 1'b0;
    resp_word1 = BUS_W'(3'b010);
    val1 = 1'b1;
    tick();
    val1 = 1'b0;
    repeat (2) tick();
    shift_en = 1'b1;
    tick();
    check("stall_enter_out", shift_out1, 0);
    resp_rdy = 1'b1;
    shift_en = 1'b1; tick(); check("stall_c1", shift_out1, 1);
    shift_en = 1'b0; tick(); check("stall_c2", shift_out1, 1);
    shift_en = 1'b0; tick(); check("stall_c3", shift_out1, 1);
    shift_en = 1'b1; tick(); check("stall_c4", shift_out1, 0);
    check("stall_rdy_ignored", req_rdy1, 0);
    check("stall_no_resp_val", resp_val1, 0);
    n = 0;
    while (!req_rdy1 && n < 200) begin
      tick();
      n++;
    end
    check("stall_remaining_shifts", n, 92);
    check("stall_xact", xact1, 3);

    // Priority: rdy and shift_en together in HOLD go to IDLE
    val1 = 1'b1;
    tick();
    val1 = 1'b0;
    repeat (2) tick();
    check("prio_hold", resp_val1, 1);
    tick();
    check("prio_idle", req_rdy1, 1);
    check("prio_out", shift_out1, 0);
    check("prio_xact", xact1, 4);
    shift_en = 1'b0;

    // Reset during WAIT on the latency-3 instance (also clears dut1)
    val3 = 1'b1;
    tick();
    val3 = 1'b0;
    tick();
    check("rstmid_in_wait", req_rdy3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_idle", req_rdy3, 1);
    check("rstmid_core_val", core_val3, 0);
    check("rstmid_xact3", xact3, 0);
    check("rstmid_xact1", xact1, 0);
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_val3) resp_seen++;
      tick();
    end
    check("rstmid_no_resp", resp_seen, 0);
    check("rstmid_data_ignored", resp_data3, 0);
    check("rstmid_xact3_after", xact3, 0);

    // Backpressure: val held high through 10 HOLD cycles, no re-issue
    resp_rdy = 1'b0;
    val1 = 1'b1;
    tick();
    repeat (2) tick();
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_val1) strobes++;
      check("bp_hold_val", resp_val1, 1);
      tick();
    end
    check("bp_no_reissue", strobes, 0);
    check("bp_rdy_low", req_rdy1, 0);
    val1 = 1'b0;
    resp_rdy = 1'b1;
    tick();
    check("bp_xact", xact1, 1);

    // Counter wrap
    for (int i = 0; i < 254; i++) xact_dut1();
    check("wrap_255", xact1, 255);
    xact_dut1();
    check("wrap_0", xact1, 0);
    check("wrap_rdy", req_rdy1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
